// File: rtl/fetch_controller_if.sv
// fetch_controller_if: request/response bundle between the fetch controller, instruction memory and decode (perf counters under FETCH_CTRL_PERF_EN)
interface fetch_controller_if;
   logic        start;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic [31:0] mem_rdata;
   logic [31:0] inst_out;
   logic [31:0] pc_out;
   logic        inst_valid;
   logic        inst_ready;
   logic        branch_taken;
   logic [31:0] branch_target;
   logic        halted;
   logic        error;
`ifdef FETCH_CTRL_PERF_EN
   logic [31:0] fetch_count;
   logic [31:0] stall_count;
   modport master (input start, mem_rdata, inst_ready, branch_taken, branch_target,
                   output mem_req, mem_addr, inst_out, pc_out, inst_valid, halted, error, fetch_count, stall_count);
   modport slave (output start, mem_rdata, inst_ready, branch_taken, branch_target,
                  input mem_req, mem_addr, inst_out, pc_out, inst_valid, halted, error, fetch_count, stall_count);
`else
   modport master (input start, mem_rdata, inst_ready, branch_taken, branch_target,
                   output mem_req, mem_addr, inst_out, pc_out, inst_valid, halted, error);
   modport slave (output start, mem_rdata, inst_ready, branch_taken, branch_target,
                  input mem_req, mem_addr, inst_out, pc_out, inst_valid, halted, error);
`endif
endinterface

// File: rtl/fetch_controller.sv
// fetch_controller: one-at-a-time instruction fetch FSM with branch redirect and halt detection; FETCH_CTRL_PERF_EN adds saturating fetch/stall counters
module fetch_controller #(
   parameter int unsigned MEM_WORDS = 32,
   parameter logic [31:0] RESET_PC  = 32'h0
) (
   input logic clock,
   input logic reset,
   fetch_controller_if.master bus
);
   typedef enum logic [2:0] {IDLE, FETCH, WAIT, VALID, HALT} state_t;
   state_t      r_state, w_next;
   logic [31:0] r_pc, r_inst, r_pc_out;
   logic        r_error;
   logic        w_bad, w_hs;
   assign w_bad = (r_pc[1:0] != 2'b00) || ({2'b00, r_pc[31:2]} >= MEM_WORDS);
   assign w_hs  = (r_state == VALID) && bus.inst_ready;
   assign bus.mem_req    = (r_state == FETCH) && !w_bad;
   assign bus.mem_addr   = bus.mem_req ? r_pc : 32'h0;
   assign bus.inst_valid = (r_state == VALID);
   assign bus.halted     = (r_state == HALT);
   assign bus.error      = r_error;
   assign bus.inst_out   = r_inst;
   assign bus.pc_out     = r_pc_out;
   // state register
   always_ff @(posedge clock)
      r_state <= reset ? IDLE : w_next;
   // next state; HALT is absorbing until reset
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    w_next = bus.start ? FETCH : IDLE;
         FETCH:   w_next = w_bad ? HALT : WAIT;
         WAIT:    w_next = (bus.mem_rdata == 32'h0) ? HALT : VALID;
         VALID:   w_next = w_hs ? FETCH : VALID;
         default: w_next = HALT;
      endcase
   end
   // PC, instruction latch and sticky error; read data is only taken in WAIT so a reset mid-read drops it
   always_ff @(posedge clock)
      if (reset) begin
         r_pc     <= RESET_PC;
         r_inst   <= 32'h0;
         r_pc_out <= 32'h0;
         r_error  <= 1'b0;
      end else begin
         if (r_state == FETCH && w_bad) r_error <= 1'b1;
         if (r_state == WAIT && bus.mem_rdata != 32'h0) begin
            r_inst   <= bus.mem_rdata;
            r_pc_out <= r_pc;
         end
         if (w_hs) r_pc <= bus.branch_taken ? bus.branch_target : r_pc + 32'd4;
      end
`ifdef FETCH_CTRL_PERF_EN
   logic [31:0] r_fetch_count, r_stall_count;
   assign bus.fetch_count = r_fetch_count;
   assign bus.stall_count = r_stall_count;
   // saturating counts of accepted instructions and stalled VALID cycles
   always_ff @(posedge clock)
      if (reset) begin
         r_fetch_count <= 32'h0;
         r_stall_count <= 32'h0;
      end else begin
         if (w_hs && r_fetch_count != 32'hFFFF_FFFF) r_fetch_count <= r_fetch_count + 32'd1;
         if (r_state == VALID && !bus.inst_ready && r_stall_count != 32'hFFFF_FFFF)
            r_stall_count <= r_stall_count + 32'd1;
      end
`endif
endmodule

// File: tb/tb_fetch_controller.sv
// tb_fetch_controller: directed checks of fetch sequencing, stalls, branches, halts and reset (FETCH_CTRL_PERF_EN enables counter checks)
module tb_fetch_controller;
  logic clock = 1'b0;
  logic ra = 1'b1, rb = 1'b1;
  int total = 0, bad = 0;
  logic [31:0] mem [0:31];
  logic [31:0] mem4 [0:3];
  fetch_controller_if ba ();
  fetch_controller_if bb ();
  fetch_controller #(.MEM_WORDS(32), .RESET_PC(32'h0)) dut_a (.clock(clock), .reset(ra), .bus(ba));
  fetch_controller #(.MEM_WORDS(4), .RESET_PC(32'h0)) dut_b (.clock(clock), .reset(rb), .bus(bb));
  always #5 clock = ~clock;
  always @(posedge clock) if (ba.mem_req) ba.mem_rdata <= mem[ba.mem_addr[6:2]];
  always @(posedge clock) if (bb.mem_req) bb.mem_rdata <= mem4[bb.mem_addr[3:2]];
  task automatic tick();
    @(posedge clock);
    #1;
  endtask
  task automatic chk(input string t, input logic [31:0] o, input logic [31:0] e);
    total++;
    if (o !== e) begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", t, o, e);
    end
  endtask
  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 32'h0;
    for (int i = 0; i < 4; i++) mem4[i] = 32'(i + 1);
    mem[0] = 32'h00100133;
    mem[1] = 32'h000A2183;
    ba.start = 1'b0; ba.inst_ready = 1'b1; ba.branch_taken = 1'b0; ba.branch_target = 32'h0;
    bb.start = 1'b0; bb.inst_ready = 1'b1; bb.branch_taken = 1'b0; bb.branch_target = 32'h0;
    tick(); tick();
    ra = 1'b0;
    chk("rst_req", ba.mem_req, 1'b0);
    chk("rst_addr", ba.mem_addr, 32'h0);
    chk("rst_inst", ba.inst_out, 32'h0);
    chk("rst_pc", ba.pc_out, 32'h0);
    chk("rst_valid", ba.inst_valid, 1'b0);
    chk("rst_halt", ba.halted, 1'b0);
    chk("rst_err", ba.error, 1'b0);
    tick();
    chk("idle_req", ba.mem_req, 1'b0);
    ba.start = 1'b1; tick(); ba.start = 1'b0;
    chk("f0_req", ba.mem_req, 1'b1);
    chk("f0_addr", ba.mem_addr, 32'h0);
    tick();
    chk("w0_req", ba.mem_req, 1'b0);
    chk("w0_valid", ba.inst_valid, 1'b0);
    tick();
    chk("v0_valid", ba.inst_valid, 1'b1);
    chk("v0_inst", ba.inst_out, 32'h00100133);
    chk("v0_pc", ba.pc_out, 32'h0);
    tick();
    chk("f1_addr", ba.mem_addr, 32'h4);
    chk("f1_valid", ba.inst_valid, 1'b0);
    tick(); tick();
    chk("v1_inst", ba.inst_out, 32'h000A2183);
    chk("v1_pc", ba.pc_out, 32'h4);
    tick();
    chk("f2_addr", ba.mem_addr, 32'h8);
    tick(); tick();
    chk("zero_halt", ba.halted, 1'b1);
    chk("zero_err", ba.error, 1'b0);
    chk("zero_valid", ba.inst_valid, 1'b0);
`ifdef FETCH_CTRL_PERF_EN
    chk("p1_fetch", ba.fetch_count, 32'd2);
`endif
    ba.start = 1'b1; tick(); ba.start = 1'b0;
    chk("halt_start_ign", ba.halted, 1'b1);
    chk("halt_noreq", ba.mem_req, 1'b0);
    mem[0] = 32'h11; mem[1] = 32'h22; mem[2] = 32'h33; mem[6] = 32'h66;
    ra = 1'b1; tick(); ra = 1'b0;
    chk("rst2_halt", ba.halted, 1'b0);
    ba.inst_ready = 1'b0;
    ba.branch_taken = 1'b1; ba.branch_target = 32'h1A;
    ba.start = 1'b1; tick(); ba.start = 1'b0;
    tick(); tick();
    for (int i = 0; i < 5; i++) begin
      chk("stall_valid", ba.inst_valid, 1'b1);
      chk("stall_inst", ba.inst_out, 32'h11);
      chk("stall_pc", ba.pc_out, 32'h0);
      chk("stall_noreq", ba.mem_req, 1'b0);
      tick();
    end
    chk("stall_still", ba.inst_valid, 1'b1);
`ifdef FETCH_CTRL_PERF_EN
    chk("stall_count", ba.stall_count, 32'd5);
`endif
    ba.branch_taken = 1'b0; ba.inst_ready = 1'b1;
    tick();
    chk("s_f1_addr", ba.mem_addr, 32'h4);
    ba.branch_taken = 1'b1; ba.branch_target = 32'h1A;
    tick(); tick();
    chk("s_v1_pc", ba.pc_out, 32'h4);
    ba.branch_taken = 1'b0;
    tick();
    chk("br_ignored", ba.mem_addr, 32'h8);
    chk("br_ign_err", ba.error, 1'b0);
    tick(); tick();
    chk("v2_inst", ba.inst_out, 32'h33);
    ba.branch_taken = 1'b1; ba.branch_target = 32'h18;
    tick();
    ba.branch_taken = 1'b0;
    chk("br_addr", ba.mem_addr, 32'h18);
    chk("br_req", ba.mem_req, 1'b1);
    tick(); tick();
    chk("br_inst", ba.inst_out, 32'h66);
    chk("br_pc", ba.pc_out, 32'h18);
    ba.branch_taken = 1'b1; ba.branch_target = 32'h1A;
    tick();
    ba.branch_taken = 1'b0;
    chk("mis_noreq", ba.mem_req, 1'b0);
    chk("mis_nohalt", ba.halted, 1'b0);
    tick();
    chk("mis_halt", ba.halted, 1'b1);
    chk("mis_err", ba.error, 1'b1);
    chk("mis_noreq2", ba.mem_req, 1'b0);
`ifdef FETCH_CTRL_PERF_EN
    chk("p2_fetch", ba.fetch_count, 32'd4);
`endif
    ra = 1'b1; ba.start = 1'b1; ba.inst_ready = 1'b1; ba.branch_taken = 1'b1;
    tick();
    ra = 1'b0; ba.start = 1'b0; ba.branch_taken = 1'b0;
    chk("prio_err", ba.error, 1'b0);
    chk("prio_halt", ba.halted, 1'b0);
    tick();
    chk("prio_idle", ba.mem_req, 1'b0);
    ba.start = 1'b1; tick(); ba.start = 1'b0;
    tick(); tick(); tick();
    chk("pre_rst_addr", ba.mem_addr, 32'h4);
    tick();
    ra = 1'b1; tick(); ra = 1'b0;
    chk("wrst_valid", ba.inst_valid, 1'b0);
    chk("wrst_req", ba.mem_req, 1'b0);
    chk("wrst_inst", ba.inst_out, 32'h0);
    chk("wrst_pc", ba.pc_out, 32'h0);
    tick();
    chk("wrst_idle", ba.inst_valid, 1'b0);
    ba.start = 1'b1; tick(); ba.start = 1'b0;
    chk("restart_addr", ba.mem_addr, 32'h0);
    chk("restart_req", ba.mem_req, 1'b1);
    tick(); tick();
    chk("restart_inst", ba.inst_out, 32'h11);
    chk("restart_pc", ba.pc_out, 32'h0);
    rb = 1'b0;
    bb.start = 1'b1; tick(); bb.start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("b_addr", bb.mem_addr, 32'(4 * i));
      tick(); tick();
      chk("b_inst", bb.inst_out, 32'(i + 1));
      chk("b_pc", bb.pc_out, 32'(4 * i));
      tick();
    end
    chk("b_oor_noreq", bb.mem_req, 1'b0);
    tick();
    chk("b_halt", bb.halted, 1'b1);
    chk("b_err", bb.error, 1'b1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fetch_controller.md
FETCH_CONTROLLER -- requirements
Module: fetch_controller

Interface
REQ-001 SHALL have parameter MEM_WORDS, default 32: instruction memory depth in 32-bit words.
REQ-002 SHALL have parameter RESET_PC, default 32'h0: byte address of the first fetch.
REQ-003 SHALL have port clock  in  1  rising-edge clock.
REQ-004 SHALL have port reset  in  1  reset, synchronous, active-high.
REQ-005 SHALL have port start  in  1  pulse to begin fetching from IDLE.
REQ-006 SHALL have port mem_req  out  1  read strobe to instruction memory.
REQ-007 SHALL have port mem_addr  out  32  byte address presented with mem_req.
REQ-008 SHALL have port mem_rdata  in  32  memory read data, valid the cycle after mem_req.
REQ-009 SHALL have port inst_out  out  32  fetched instruction to decode.
REQ-010 SHALL have port pc_out  out  32  byte address of inst_out.
REQ-011 SHALL have port inst_valid  out  1  inst_out/pc_out valid.
REQ-012 SHALL have port inst_ready  in  1  decode accepts the instruction.
REQ-013 SHALL have port branch_taken  in  1  redirect request, qualified by the handshake.
REQ-014 SHALL have port branch_target  in  32  redirect byte address.
REQ-015 SHALL have port halted  out  1  fetch stopped.
REQ-016 SHALL have port error  out  1  halt caused by an illegal address.

Function
REQ-017 SHALL implement states IDLE, FETCH, WAIT, VALID, HALT.
REQ-018 IDLE: start=1 -> FETCH; otherwise IDLE.
REQ-019 FETCH: if PC[1:0]!=0 or PC/4>=MEM_WORDS -> HALT with error=1 and no mem_req; else assert mem_req=1, mem_addr=PC for exactly this cycle -> WAIT.
REQ-020 WAIT: capture mem_rdata; all-zero word -> HALT with error=0, inst_valid stays 0; else load inst_out=mem_rdata, pc_out=PC -> VALID.
REQ-021 VALID: inst_valid=1; inst_out and pc_out SHALL hold stable until inst_valid&inst_ready.
REQ-022 On handshake: next PC = branch_target if branch_taken=1, else PC+4 (32-bit wrap); -> FETCH.
REQ-023 branch_taken SHALL be ignored outside the VALID handshake cycle.
REQ-024 Misaligned or out-of-range branch_target SHALL be detected in the following FETCH cycle per REQ-019.
REQ-025 Throughput SHALL be one instruction per 3 cycles with inst_ready held high; latency start->inst_valid SHALL be 3 cycles.
REQ-026 HALT: halted=1, inst_valid=0, mem_req=0; start ignored; only reset exits.
REQ-027 mem_req SHALL be asserted only in FETCH.

Reset
REQ-028 On reset: state=IDLE, PC=RESET_PC, mem_req=0, mem_addr=0, inst_out=0, pc_out=0, inst_valid=0, halted=0, error=0.
REQ-029 Reset asserted in any state, including WAIT with a read in flight, SHALL discard the pending read data.
REQ-030 reset SHALL take priority over start, inst_ready and branch_taken in the same cycle.

Configuration
REQ-031 With FETCH_CTRL_PERF_EN defined: outputs fetch_count[31:0] (+1 per accepted handshake) and stall_count[31:0] (+1 per VALID cycle with inst_ready=0), both reset to 0 and saturating at 32'hFFFFFFFF.
REQ-032 Without FETCH_CTRL_PERF_EN: neither port nor counter logic exists; all other behaviour is identical.

Verification
REQ-033 Memory {0x00100133, 0x000A2183, 0}, start pulse, inst_ready=1 -> handshakes at pc 0x0 and 0x4, then halted=1, error=0.
REQ-034 inst_ready=0 for 5 cycles in VALID -> inst_out/pc_out stable, no mem_req; stall_count=5 with PERF_EN defined.
REQ-035 Handshake at pc 0x8 with branch_taken=1, target=0x18 -> next mem_addr=0x18.
REQ-036 Branch target 0x1A -> HALT, error=1, no mem_req issued.
REQ-037 MEM_WORDS=4, nonzero words 0..3 -> after pc 0xC, PC=0x10 -> halted=1, error=1.
REQ-038 reset asserted in WAIT -> next cycle state IDLE, inst_valid=0, PC=RESET_PC; new start re-fetches from RESET_PC.
